// File: rtl/udp_cam_pkg.sv
// Shared types and constants for the camera-to-UDP packet scheduler.
// UDP_SCHED_HDR_EN selects the 4-byte frame/line/segment header.
package udp_cam_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_PAYLOAD,
        S_DRAIN,
        S_GAP
    } sched_state_t;

`ifdef UDP_SCHED_HDR_EN
    localparam int unsigned HDR_BYTES = 4;
`else
    localparam int unsigned HDR_BYTES = 0;
`endif

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned LINE_W  = 15;
    localparam int unsigned LEN_W   = 16;

endpackage

// File: rtl/udp_pixel_scheduler_if.sv
// Scheduler-to-UDP-engine packet handshake; the scheduler is the master.
interface udp_pixel_scheduler_if;
    import udp_cam_pkg::*;

    logic             tx_req;
    logic             tx_ack;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_last;
    logic [LEN_W-1:0] tx_len;

    modport master (
        output tx_req, tx_data, tx_valid, tx_last, tx_len,
        input  tx_ack
    );

    modport slave (
        input  tx_req, tx_data, tx_valid, tx_last, tx_len,
        output tx_ack
    );

endinterface

// File: rtl/udp_sched_counters.sv
// Segment/line/frame numbering with deferred frame_sync while a packet is in flight.
module udp_sched_counters
    import udp_cam_pkg::*;
#(
    parameter int unsigned IM_Y = 720
) (
    input  logic               gtx_clk,
    input  logic               rst_n,
    input  logic               pkt_done,
    input  logic               frame_sync,
    input  logic               busy,
    output logic               seg,
    output logic [LINE_W-1:0]  line_cnt,
    output logic [FRAME_W-1:0] frame_cnt
);

    logic pending;

    always_ff @(posedge gtx_clk or negedge rst_n) begin
        if (!rst_n) begin
            seg       <= 1'b0;
            line_cnt  <= '0;
            frame_cnt <= '0;
            pending   <= 1'b0;
        end else if (pkt_done) begin
            // A sync seen during the packet, or on its final cycle, replaces the normal step.
            if (pending || frame_sync) begin
                seg       <= 1'b0;
                line_cnt  <= '0;
                frame_cnt <= frame_cnt + 1'b1;
                pending   <= 1'b0;
            end else if (!seg) begin
                seg <= 1'b1;
            end else begin
                seg <= 1'b0;
                if (line_cnt == LINE_W'(IM_Y - 1)) begin
                    line_cnt  <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end
        end else if (frame_sync) begin
            if (busy) begin
                pending <= 1'b1;
            end else begin
                seg       <= 1'b0;
                line_cnt  <= '0;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_pixel_scheduler.sv
// Paces RGB565 FIFO reads into fixed-size UDP payload packets with an inter-packet gap.
// UDP_SCHED_HDR_EN prepends a 4-byte frame/line/segment header.
module udp_pixel_scheduler
    import udp_cam_pkg::*;
#(
    parameter int unsigned IM_X    = 1280,
    parameter int unsigned IM_Y    = 720,
    parameter int unsigned IFG_CYC = 16
) (
    input  logic                  gtx_clk,
    input  logic                  rst_n,
    input  logic [$clog2(IM_X):0] fifo_level,
    output logic                  out_ready,
    input  logic [7:0]            pixel,
    input  logic                  pixel_valid,
    input  logic                  frame_sync,
    udp_pixel_scheduler_if.master tx
);

    localparam int unsigned PKT_BYTES = IM_X;
    localparam int unsigned LVL_W     = $clog2(IM_X) + 1;
    localparam int unsigned CNT_W     = $clog2(IM_X + IFG_CYC + 4);
    localparam logic [LEN_W-1:0] TX_LEN = LEN_W'(PKT_BYTES + HDR_BYTES);

    sched_state_t       state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               pkt_done;
    logic               busy;
    logic               seg;
    logic [LINE_W-1:0]  line_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic [7:0]         hdr_byte;

    assign busy = (state == S_REQ) || (state == S_HDR) ||
                  (state == S_PAYLOAD) || (state == S_DRAIN);

    udp_sched_counters #(
        .IM_Y (IM_Y)
    ) u_counters (
        .gtx_clk    (gtx_clk),
        .rst_n      (rst_n),
        .pkt_done   (pkt_done),
        .frame_sync (frame_sync),
        .busy       (busy),
        .seg        (seg),
        .line_cnt   (line_cnt),
        .frame_cnt  (frame_cnt)
    );

    always_comb begin
        hdr_byte = '0;
        case (cnt[1:0])
            2'd0:    hdr_byte = frame_cnt[15:8];
            2'd1:    hdr_byte = frame_cnt[7:0];
            2'd2:    hdr_byte = {seg, line_cnt[14:8]};
            default: hdr_byte = line_cnt[7:0];
        endcase
    end

    always_ff @(posedge gtx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        out_ready   = 1'b0;
        pkt_done    = 1'b0;
        tx.tx_req   = 1'b0;
        tx.tx_len   = '0;
        tx.tx_valid = 1'b0;
        tx.tx_last  = 1'b0;
        tx.tx_data  = '0;
        case (state)
            S_IDLE: begin
                if (fifo_level >= LVL_W'(PKT_BYTES)) state_next = S_REQ;
            end
            S_REQ: begin
                tx.tx_req = 1'b1;
                tx.tx_len = TX_LEN;
                if (tx.tx_ack) begin
                    cnt_next = '0;
`ifdef UDP_SCHED_HDR_EN
                    state_next = S_HDR;
`else
                    state_next = S_PAYLOAD;
`endif
                end
            end
            S_HDR: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = hdr_byte;
                cnt_next    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(3)) begin
                    cnt_next   = '0;
                    state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // Read data lags out_ready by one cycle, so bytes start on the 2nd cycle.
                out_ready = 1'b1;
                if (cnt != '0) begin
                    tx.tx_valid = pixel_valid;
                    tx.tx_data  = pixel;
                end
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(PKT_BYTES - 1)) begin
                    cnt_next   = '0;
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                tx.tx_valid = pixel_valid;
                tx.tx_data  = pixel;
                tx.tx_last  = pixel_valid;
                pkt_done    = 1'b1;
                cnt_next    = '0;
                state_next  = S_GAP;
            end
            S_GAP: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(IFG_CYC - 1)) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_udp_pixel_scheduler.sv
// Directed scoreboard bench for udp_pixel_scheduler (IM_X=20, IM_Y=4, IFG_CYC=3), either header build.
module tb_udp_pixel_scheduler;

    localparam int unsigned IM_X    = 20;
    localparam int unsigned IM_Y    = 4;
    localparam int unsigned IFG_CYC = 3;
    localparam int unsigned LVL_W   = $clog2(IM_X) + 1;
`ifdef UDP_SCHED_HDR_EN
    localparam int unsigned HDR_B = 4;
`else
    localparam int unsigned HDR_B = 0;
`endif

    logic             gtx_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [LVL_W-1:0] fifo_level = '0;
    logic             out_ready;
    logic [7:0]       pixel = '0;
    logic             pixel_valid = 1'b0;
    logic             frame_sync = 1'b0;

    udp_pixel_scheduler_if bus ();

    udp_pixel_scheduler #(
        .IM_X    (IM_X),
        .IM_Y    (IM_Y),
        .IFG_CYC (IFG_CYC)
    ) dut (
        .gtx_clk     (gtx_clk),
        .rst_n       (rst_n),
        .fifo_level  (fifo_level),
        .out_ready   (out_ready),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .frame_sync  (frame_sync),
        .tx          (bus)
    );

    always #5 gtx_clk = ~gtx_clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          pkts_done = 0;
    int          rd_run = 0;
    int          idle_run = 0;
    bit          in_pkt = 1'b0;
    time         last_t = 0;

    logic [15:0] frame_m = '0;
    logic [14:0] line_m = '0;
    bit          seg_m = 1'b0;
    bit          pend_m = 1'b0;
    int unsigned base_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // FIFO model: one-cycle read latency, incrementing byte stream restarting at reset.
    initial begin : fifo_model
        logic       rd;
        logic [7:0] nxt;
        nxt = '0;
        forever begin
            @(negedge gtx_clk);
            rd = out_ready;
            @(posedge gtx_clk);
            #1;
            if (!rst_n) begin
                nxt = '0;
                pixel_valid = 1'b0;
            end else if (rd) begin
                pixel = nxt;
                pixel_valid = 1'b1;
                nxt = nxt + 8'd1;
            end else begin
                pixel_valid = 1'b0;
            end
        end
    end

    always @(negedge gtx_clk) begin
        if (!rst_n) begin
            rd_run = 0;
            idle_run = 0;
            in_pkt = 1'b0;
        end else begin
            if (out_ready) rd_run++;
            if (bus.tx_valid) begin
                if (in_pkt) chk("byte_spacing", 32'(idle_run <= 1), 1);
                idle_run = 0;
                in_pkt = 1'b1;
                chk("unexpected_byte", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("tx_byte_last", {23'd0, bus.tx_last, bus.tx_data}, {23'd0, mon_e.last, mon_e.data});
                end
                if (bus.tx_last) begin
                    chk("read_cycles", rd_run, IM_X);
                    rd_run = 0;
                    in_pkt = 1'b0;
                    last_t = $time;
                    pkts_done++;
                end
            end else if (in_pkt) begin
                idle_run++;
            end
        end
    end

    task automatic push_pkt();
        exp_t e;
`ifdef UDP_SCHED_HDR_EN
        e.last = 1'b0;
        e.data = frame_m[15:8];          exp_q.push_back(e);
        e.data = frame_m[7:0];           exp_q.push_back(e);
        e.data = {seg_m, line_m[14:8]};  exp_q.push_back(e);
        e.data = line_m[7:0];            exp_q.push_back(e);
`endif
        for (int unsigned i = 0; i < IM_X; i++) begin
            e.data = 8'((base_m + i) & 32'hFF);
            e.last = (i == IM_X - 1);
            exp_q.push_back(e);
        end
        base_m = base_m + IM_X;
    endtask

    task automatic step_model();
        if (pend_m) begin
            frame_m = frame_m + 16'd1;
            line_m = '0;
            seg_m = 1'b0;
            pend_m = 1'b0;
        end else if (!seg_m) begin
            seg_m = 1'b1;
        end else begin
            seg_m = 1'b0;
            if (line_m == 15'(IM_Y - 1)) begin
                line_m = '0;
                frame_m = frame_m + 16'd1;
            end else begin
                line_m = line_m + 15'd1;
            end
        end
    endtask

    // action: 0 none, 1 frame_sync mid-payload, 2 stray tx_ack mid-payload, 3 reset at payload cycle 10
    task automatic do_packet(input int ack_dly, input int action, input bit gap_chk);
        int target;
        int idle;
        for (int n = 0; n < 200 && bus.tx_req !== 1'b1; n++) @(negedge gtx_clk);
        chk("tx_req_seen", 32'(bus.tx_req), 1);
        chk("tx_len", 32'(bus.tx_len), IM_X + HDR_B);
        if (gap_chk) begin
            idle = int'(($time - last_t) / 10) - 1;
            chk("ifg_range", 32'((idle >= int'(IFG_CYC)) && (idle <= int'(IFG_CYC) + 1)), 1);
        end
        repeat (ack_dly) @(negedge gtx_clk);
        chk("tx_req_held", 32'(bus.tx_req), 1);
        push_pkt();
        target = pkts_done + 1;
        bus.tx_ack = 1'b1;
        @(negedge gtx_clk);
        bus.tx_ack = 1'b0;
        if (action != 0) begin
            for (int n = 0; n < 20 && out_ready !== 1'b1; n++) @(negedge gtx_clk);
            chk("payload_start", 32'(out_ready), 1);
            if (action == 1) begin
                repeat (4) @(negedge gtx_clk);
                frame_sync = 1'b1;
                pend_m = 1'b1;
                @(negedge gtx_clk);
                frame_sync = 1'b0;
            end else if (action == 2) begin
                repeat (4) @(negedge gtx_clk);
                bus.tx_ack = 1'b1;
                @(negedge gtx_clk);
                bus.tx_ack = 1'b0;
            end else begin
                repeat (9) @(negedge gtx_clk);
                rst_n = 1'b0;
                #1;
                chk("reset_mid_outputs", {20'd0, out_ready, bus.tx_req, bus.tx_valid, bus.tx_last, bus.tx_data}, 0);
                chk("reset_mid_len", 32'(bus.tx_len), 0);
                exp_q.delete();
                frame_m = '0; line_m = '0; seg_m = 1'b0; pend_m = 1'b0; base_m = 0;
                repeat (3) @(negedge gtx_clk);
                rst_n = 1'b1;
                return;
            end
        end
        for (int n = 0; n < 300 && pkts_done != target; n++) @(negedge gtx_clk);
        chk("pkt_complete", pkts_done, target);
        step_model();
    endtask

    initial begin
        bus.tx_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge gtx_clk);
        chk("reset_outputs", {20'd0, out_ready, bus.tx_req, bus.tx_valid, bus.tx_last, bus.tx_data}, 0);
        chk("reset_len", 32'(bus.tx_len), 0);
        rst_n = 1'b1;

        fifo_level = LVL_W'(IM_X - 1);
        repeat (6) @(negedge gtx_clk);
        chk("no_req_below_level", 32'(bus.tx_req), 0);
        fifo_level = LVL_W'(IM_X);
        @(negedge gtx_clk);
        chk("req_next_cycle", 32'(bus.tx_req), 1);

        do_packet(5, 0, 1'b0);
        do_packet(0, 2, 1'b1);
        for (int i = 2; i < 10; i++) do_packet(i % 3, 0, 1'b1);
        do_packet(1, 1, 1'b1);
        do_packet(0, 0, 1'b1);

        fifo_level = '0;
        repeat (8) @(negedge gtx_clk);
        chk("no_req_when_empty", 32'(bus.tx_req), 0);
        frame_sync = 1'b1;
        @(negedge gtx_clk);
        frame_sync = 1'b0;
        frame_m = frame_m + 16'd1; line_m = '0; seg_m = 1'b0;
        fifo_level = LVL_W'(IM_X);
        do_packet(2, 0, 1'b0);

        do_packet(1, 3, 1'b1);
        do_packet(0, 0, 1'b0);

        fifo_level = '0;
        repeat (10) @(negedge gtx_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
